// File: rtl/penalty_shootout_ctrl.sv
// penalty_shootout_ctrl: two-team penalty shootout with early finish and sudden death
module penalty_shootout_ctrl #(
    parameter int N_SHORT = 3,
    parameter int N_LONG  = 5,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_m1,
    input  logic          btn_m2,
    input  logic          kick,
    input  logic          goal,
    output logic          mode,
    output logic          busy,
    output logic          fin,
    output logic [1:0]    winner,
    output logic          turn,
    output logic          sudden,
    output logic [CW-1:0] score_a,
    output logic [CW-1:0] score_b,
    output logic [CW-1:0] shots_a,
    output logic [CW-1:0] shots_b,
    output logic [CW-1:0] sd_round
);
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_SUDDEN, S_DONE} state_t;
    state_t        r_state, w_state;
    logic          r_prev_m1, r_prev_m2, r_mode, r_busy, r_fin, r_turn, r_sudden, r_sd_a;
    logic          w_mode, w_busy, w_fin, w_turn, w_sudden, w_sd_a;
    logic [1:0]    r_winner, w_winner;
    logic [CW-1:0] r_score_a, r_score_b, r_shots_a, r_shots_b, r_sd_round;
    logic [CW-1:0] w_score_a, w_score_b, w_shots_a, w_shots_b, w_sd_round;
    logic          w_e1, w_e2, w_kick_a, w_kick_b;
    logic [CW-1:0] w_inc_a, w_inc_b, w_psh_a, w_psh_b;
    logic [CW:0]   w_n, w_rem_a, w_rem_b;
    assign w_e1     = btn_m1 & ~r_prev_m1;
    assign w_e2     = btn_m2 & ~r_prev_m2;
    assign w_kick_a = kick & ~r_turn;
    assign w_kick_b = kick & r_turn;
    assign w_inc_a  = (goal & w_kick_a & ~&r_score_a) ? r_score_a + 1'b1 : r_score_a;
    assign w_inc_b  = (goal & w_kick_b & ~&r_score_b) ? r_score_b + 1'b1 : r_score_b;
    assign w_psh_a  = w_kick_a ? r_shots_a + 1'b1 : r_shots_a;
    assign w_psh_b  = w_kick_b ? r_shots_b + 1'b1 : r_shots_b;
    assign w_n      = r_mode ? (CW+1)'(N_LONG) : (CW+1)'(N_SHORT);
    assign w_rem_a  = w_n - {1'b0, w_psh_a};
    assign w_rem_b  = w_n - {1'b0, w_psh_b};
    always_comb begin
        w_state    = r_state;
        w_mode     = r_mode;
        w_busy     = r_busy;
        w_fin      = r_fin;
        w_winner   = r_winner;
        w_turn     = r_turn;
        w_sudden   = r_sudden;
        w_sd_a     = r_sd_a;
        w_score_a  = r_score_a;
        w_score_b  = r_score_b;
        w_shots_a  = r_shots_a;
        w_shots_b  = r_shots_b;
        w_sd_round = r_sd_round;
        case (r_state)
            S_IDLE, S_DONE: if (w_e1 ^ w_e2) begin
                w_state    = S_PLAY;
                w_mode     = w_e2;
                w_busy     = 1'b1;
                w_fin      = 1'b0;
                w_winner   = 2'b00;
                w_turn     = 1'b0;
                w_sudden   = 1'b0;
                w_score_a  = '0;
                w_score_b  = '0;
                w_shots_a  = '0;
                w_shots_b  = '0;
                w_sd_round = '0;
            end
            S_PLAY: if (kick) begin
                w_turn    = ~r_turn;
                w_score_a = w_inc_a;
                w_score_b = w_inc_b;
                w_shots_a = w_psh_a;
                w_shots_b = w_psh_b;
                // A side is out of reach once its lead exceeds what the other side can still score
                if ({1'b0, w_inc_a} > {1'b0, w_inc_b} + w_rem_b) begin
                    w_state  = S_DONE;
                    w_winner = 2'b01;
                    w_fin    = 1'b1;
                    w_busy   = 1'b0;
                end else if ({1'b0, w_inc_b} > {1'b0, w_inc_a} + w_rem_a) begin
                    w_state  = S_DONE;
                    w_winner = 2'b10;
                    w_fin    = 1'b1;
                    w_busy   = 1'b0;
                end else if (w_rem_a == '0 && w_rem_b == '0) begin
                    w_state  = S_SUDDEN;
                    w_sudden = 1'b1;
                end
            end
            S_SUDDEN: if (kick) begin
                w_turn    = ~r_turn;
                w_score_a = w_inc_a;
                w_score_b = w_inc_b;
                w_sd_a    = r_turn ? r_sd_a : goal;
                if (r_turn && goal != r_sd_a) begin
                    w_state  = S_DONE;
                    w_winner = r_sd_a ? 2'b01 : 2'b10;
                    w_fin    = 1'b1;
                    w_busy   = 1'b0;
                end else if (r_turn) begin
                    w_sd_round = r_sd_round + 1'b1;
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_prev_m1  <= 1'b0;
            r_prev_m2  <= 1'b0;
            r_mode     <= 1'b0;
            r_busy     <= 1'b0;
            r_fin      <= 1'b0;
            r_winner   <= 2'b00;
            r_turn     <= 1'b0;
            r_sudden   <= 1'b0;
            r_sd_a     <= 1'b0;
            r_score_a  <= '0;
            r_score_b  <= '0;
            r_shots_a  <= '0;
            r_shots_b  <= '0;
            r_sd_round <= '0;
        end else begin
            r_state    <= w_state;
            r_prev_m1  <= btn_m1;
            r_prev_m2  <= btn_m2;
            r_mode     <= w_mode;
            r_busy     <= w_busy;
            r_fin      <= w_fin;
            r_winner   <= w_winner;
            r_turn     <= w_turn;
            r_sudden   <= w_sudden;
            r_sd_a     <= w_sd_a;
            r_score_a  <= w_score_a;
            r_score_b  <= w_score_b;
            r_shots_a  <= w_shots_a;
            r_shots_b  <= w_shots_b;
            r_sd_round <= w_sd_round;
        end
    end
    assign mode     = r_mode;
    assign busy     = r_busy;
    assign fin      = r_fin;
    assign winner   = r_winner;
    assign turn     = r_turn;
    assign sudden   = r_sudden;
    assign score_a  = r_score_a;
    assign score_b  = r_score_b;
    assign shots_a  = r_shots_a;
    assign shots_b  = r_shots_b;
    assign sd_round = r_sd_round;
endmodule

// File: tb/tb_penalty_shootout_ctrl.sv
// tb_penalty_shootout_ctrl: vector table, directed corner sequences and random play against a score model
module tb_penalty_shootout_ctrl;
    localparam int CW = 4, NS = 3, NL = 5, SMAX = 15;
    logic clk = 1'b0, rst = 1'b1, btn_m1 = 1'b0, btn_m2 = 1'b0, kick = 1'b0, goal = 1'b0;
    logic mode, busy, fin, turn, sudden;
    logic [1:0] winner;
    logic [CW-1:0] score_a, score_b, shots_a, shots_b, sd_round;
    logic [26:0] dvec;
    int n_tests = 0, n_fail = 0;
    int ph = 0, sc[2] = '{0, 0}, sh[2] = '{0, 0}, sdr = 0, win = 0;
    bit md = 0, tn = 0, sdd = 0, fn = 0, sda = 0, p1 = 0, p2 = 0;

    always #5 clk = ~clk;

    penalty_shootout_ctrl #(.N_SHORT(NS), .N_LONG(NL), .CW(CW)) dut (
        .clk(clk), .rst(rst), .btn_m1(btn_m1), .btn_m2(btn_m2), .kick(kick), .goal(goal),
        .mode(mode), .busy(busy), .fin(fin), .winner(winner), .turn(turn), .sudden(sudden),
        .score_a(score_a), .score_b(score_b), .shots_a(shots_a), .shots_b(shots_b),
        .sd_round(sd_round)
    );

    assign dvec = {mode, busy, fin, winner, turn, sudden, score_a, score_b, shots_a, shots_b, sd_round};

    // ph: 0 idle, 1 regulation, 2 sudden death, 3 decided
    task automatic mstep(input bit r, input bit b1, input bit b2, input bit k, input bit g);
        bit e1, e2;
        int t, n;
        if (r) begin
            ph = 0; md = 0; tn = 0; sdd = 0; fn = 0; sda = 0; p1 = 0; p2 = 0;
            sc = '{0, 0}; sh = '{0, 0}; sdr = 0; win = 0;
            return;
        end
        e1 = b1 && !p1;
        e2 = b2 && !p2;
        p1 = b1;
        p2 = b2;
        n = md ? NL : NS;
        t = tn ? 1 : 0;
        if ((ph == 0 || ph == 3) && e1 != e2) begin
            ph = 1; md = e2; tn = 0; sdd = 0; fn = 0; win = 0;
            sc = '{0, 0}; sh = '{0, 0}; sdr = 0;
        end else if (ph == 1 && k) begin
            sh[t]++;
            if (g) sc[t]++;
            tn = !tn;
            if (sc[0] > sc[1] + (n - sh[1])) begin win = 1; ph = 3; fn = 1; end
            else if (sc[1] > sc[0] + (n - sh[0])) begin win = 2; ph = 3; fn = 1; end
            else if (sh[0] == n && sh[1] == n) begin ph = 2; sdd = 1; end
        end else if (ph == 2 && k) begin
            if (g && sc[t] < SMAX) sc[t]++;
            if (t == 0) sda = g;
            else if (g != sda) begin win = sda ? 1 : 2; ph = 3; fn = 1; end
            else sdr = (sdr + 1) % 16;
            tn = !tn;
        end
    endtask

    function automatic logic [26:0] mvec();
        return {md, 1'(ph == 1 || ph == 2), fn, 2'(win), tn, sdd,
                4'(sc[0]), 4'(sc[1]), 4'(sh[0]), 4'(sh[1]), 4'(sdr)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit b1, input bit b2, input bit k, input bit g);
        rst = r; btn_m1 = b1; btn_m2 = b2; kick = k; goal = g;
        @(posedge clk);
        #1;
        mstep(r, b1, b2, k, g);
        chk("model", dvec, mvec());
    endtask

    task automatic kk(input bit g);
        cyc(0, btn_m1, btn_m2, 1, g);
    endtask

    typedef struct {
        bit r, m1, m2, k, g;
        int busy, fin, mode, turn, win, sa, sb, ha, hb;
    } vec_t;

    vec_t tbl[11] = '{
        '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0},
        '{0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0},
        '{0, 1, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0},
        '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0},
        '{0, 1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 0},
        '{0, 1, 0, 1, 1,  1, 0, 0, 1, 0,  1, 0, 1, 0},
        '{0, 1, 0, 1, 0,  1, 0, 0, 0, 0,  1, 0, 1, 1},
        '{0, 1, 0, 1, 1,  1, 0, 0, 1, 0,  2, 0, 2, 1},
        '{0, 0, 0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 2},
        '{0, 0, 0, 1, 1,  0, 1, 0, 0, 1,  2, 0, 2, 2},
        '{0, 1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 0}
    };

    initial begin
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].r, tbl[i].m1, tbl[i].m2, tbl[i].k, tbl[i].g);
            chk($sformatf("vec%0d", i), {busy, fin, mode, turn, winner, score_a, score_b, shots_a, shots_b},
                {1'(tbl[i].busy), 1'(tbl[i].fin), 1'(tbl[i].mode), 1'(tbl[i].turn), 2'(tbl[i].win),
                 4'(tbl[i].sa), 4'(tbl[i].sb), 4'(tbl[i].ha), 4'(tbl[i].hb)});
        end
        cyc(0, 1, 1, 0, 0);
        chk("m2_in_play", {busy, mode}, 2'b10);
        kk(1); kk(0); kk(1);
        chk("three_kicks", {busy, fin, score_a, shots_a, shots_b}, {2'b10, 4'd2, 4'd2, 4'd1});
        cyc(1, 0, 0, 0, 0);
        chk("rst_mid", dvec, 27'd0);
        cyc(0, 0, 1, 0, 0);
        chk("m2_after_rst", {busy, mode, fin}, 3'b110);
        for (int i = 0; i < 10; i++) kk(1);
        chk("sd_entry", {sudden, busy, score_a, score_b, shots_a, shots_b}, {2'b11, 4'd5, 4'd5, 4'd5, 4'd5});
        kk(1); kk(0);
        chk("sd_a_wins", {fin, busy, winner, score_a, score_b, sd_round}, {2'b10, 2'b01, 4'd6, 4'd5, 4'd0});
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) kk(1);
        for (int i = 0; i < 4; i++) kk(0);
        chk("sd_rounds", {busy, sudden, sd_round}, {2'b11, 4'd2});
        kk(0); kk(1);
        chk("sd_b_wins", {fin, winner, score_a, score_b}, {1'b1, 2'b10, 4'd5, 4'd6});
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) kk(1);
        for (int i = 0; i < 34; i++) kk(1);
        chk("sat_wrap", {busy, score_a, score_b, sd_round, shots_a}, {1'b1, 4'd15, 4'd15, 4'd1, 4'd5});
        kk(0); kk(1);
        chk("sat_decide", {fin, busy, winner, score_b}, {2'b10, 2'b10, 4'd15});
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, i == 3, 1);
        chk("held_m1", {busy, mode, score_a, shots_a, turn}, {2'b10, 4'd1, 4'd1, 1'b1});
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 299) == 0,
                ($urandom_range(0, 15) == 0) ? ~btn_m1 : btn_m1,
                ($urandom_range(0, 15) == 0) ? ~btn_m2 : btn_m2,
                $urandom_range(0, 2) != 0, 1'($urandom));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/penalty_shootout_ctrl.md
# penalty_shootout_ctrl

Parametrised two-team penalty-shootout controller. Mode buttons select a short or long regulation series. Kicks alternate between team A and team B, with a shared goal flag recording whether each kick scored. The block keeps shots and scores per team, ends the series early once the result can no longer change, and runs sudden-death rounds after a regulation tie. It sits between the debounced player push-buttons and the score display/decoder logic.

## Interface
Parameters:
- N_SHORT, 3, regulation kicks per team in short mode
- N_LONG, 5, regulation kicks per team in long mode
- CW, 4, width of score/shot/round counters; must satisfy 2^CW-1 >= N_LONG

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- btn_m1  in  1  short-mode request, level; rising edge detected internally
- btn_m2  in  1  long-mode request, level; rising edge detected internally
- kick  in  1  one-cycle pulse: current kicker has shot
- goal  in  1  sampled with kick: 1 = scored, 0 = missed
- mode  out  1  0 = short, 1 = long (valid while busy or fin)
- busy  out  1  series in progress (PLAY or SUDDEN)
- fin  out  1  series decided
- winner  out  2  00 none, 01 team A, 10 team B
- turn  out  1  0 = A kicks next, 1 = B kicks next
- sudden  out  1  in sudden death
- score_a, score_b  out  CW  goals per team, saturating
- shots_a, shots_b  out  CW  regulation kicks per team
- sd_round  out  CW  completed sudden-death rounds, wraps modulo 2^CW

## Operation
- Edge detect: prev_m1/prev_m2 registers; edge = btn & ~prev. Both registers reset to 0. A held button produces exactly one edge.
- States: IDLE, PLAY, SUDDEN, DONE. Reset puts the block in IDLE and clears every output to 0.
- IDLE:
  - m1 edge alone: mode=0, go to PLAY.
  - m2 edge alone: mode=1, go to PLAY.
  - Both edges in the same cycle: ignored, stay IDLE.
  - kick ignored.
- Entering PLAY from IDLE or DONE clears scores, shots, sd_round, turn, winner, fin and sudden.
- PLAY:
  - kick increments shots of the turn team; goal=1 also increments that team's score; turn toggles.
  - Let N = mode ? N_LONG : N_SHORT, rem_x = N − shots_x after the update. Compare in CW+1 bits.
  - score_a > score_b + rem_b: DONE, winner=01.
  - score_b > score_a + rem_a: DONE, winner=10.
  - Otherwise, if shots_a = shots_b = N with equal scores: SUDDEN, sudden=1.
- SUDDEN:
  - A's kick latches goal into sd_a; score_a increments on goal; turn toggles.
  - B's kick: score_b increments on goal; turn toggles.
  - If goal ≠ sd_a: DONE, winner = sd_a ? 01 : 10.
  - Otherwise sd_round increments and the block stays in SUDDEN.
  - shots_a/shots_b hold at N.
  - The decision uses sd_a and goal only, never the counters, so score saturation cannot change the result.
- DONE: fin=1. Counters, winner and sudden hold. kick ignored. A single mode edge starts a new series exactly as from IDLE.
- Mode edges during PLAY or SUDDEN are ignored, and prev registers keep tracking.
- Score counters saturate at 2^CW−1. sd_round wraps.

## Timing
- All outputs are registered.
- kick at cycle t: counters, turn, fin, winner and sudden are updated and visible at t+1.
- Mode edge: the button rises at cycle t, the edge is registered at t, and busy=1 with mode valid at t+1.
- fin and busy are mutually exclusive. fin rises in the cycle after the deciding kick; busy falls in the same cycle.
- Back-to-back kick pulses on consecutive cycles are each accepted.
- rst has priority over every other input on any edge. Mid-series reset returns to IDLE with all outputs 0 at the next cycle.

## Test plan
- Short mode, early finish: m1 edge; kicks A goal, B miss, A goal, B miss. Expected: no fin after the 3rd kick; after the 4th, fin=1, winner=01, score 2–0, shots 2/2, busy=0.
- Long mode, sudden death: m2 edge; 10 kicks all goal. Expected: sudden=1, score 5–5, shots 5/5. Then A goal, B miss. Expected: fin=1, winner=01, score 6–5, sd_round=0.
- Long sudden-death rounds: tie at 5–5, then two rounds of miss/miss. Expected: sd_round=2, busy=1. Then A miss, B goal. Expected: winner=10.
- Mode-button handling: m1 and m2 rise in the same cycle while in IDLE. Expected: stays IDLE, busy=0. Held m1 for 10 cycles. Expected: exactly one series start. m2 edge during PLAY. Expected: mode unchanged.
- Ignored kicks and restart: kick in IDLE. Expected: all counters 0. After a decided series, a kick in DONE. Expected: counters hold. Then an m1 edge. Expected: counters cleared, busy=1, turn=0.
- Reset mid-series: rst after 3 kicks in PLAY. Expected: next cycle IDLE, all outputs 0. A subsequent m2 edge starts a long series normally.
